shift_ctrl: RTL
===============

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 6, which sets the word width and the shift-chain depth.
REQ-002 clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  producer offers in_data.
REQ-005 in_ready  output  1  controller can accept a word.
REQ-006 in_data  input  WIDTH  parallel word to transfer through the chain.
REQ-007 out_valid  output  1  out_data holds a completed word.
REQ-008 out_ready  input  1  consumer accepts out_data.
REQ-009 out_data  output  WIDTH  parallel contents of the shift chain.
REQ-010 sdo  output  1  serial bit currently driven into the chain input.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid 0; all other states SHALL drive in_ready 0.
REQ-014 A word SHALL be accepted on a clock edge where in_valid=1 and in_ready=1.
- in_data latched into an internal hold register.
- bit counter cleared to 0.
- IDLE->SHIFT.
REQ-015 In SHIFT, the chain SHALL shift one stage per clock (stage k+1 -> stage k, sdo -> top stage), with sdo = hold[cnt].
REQ-016 The bit counter SHALL increment once per SHIFT cycle and be $clog2(WIDTH) bits wide, with no wrap beyond WIDTH-1.
REQ-017 The edge with cnt=WIDTH-1 SHALL perform the last shift and move SHIFT->HOLD.
REQ-018 Transfer order SHALL be LSB first, so that on entry to HOLD, out_data[i] = accepted in_data[i] for all i.
REQ-019 Latency: out_valid SHALL assert exactly WIDTH clock edges after the accept edge.
REQ-020 The chain SHALL hold its contents (no shift) in IDLE and HOLD.
REQ-021 In HOLD, out_valid SHALL be 1; out_data SHALL remain stable until out_ready=1 is sampled, then HOLD->IDLE.
REQ-022 Back-pressure: out_ready=0 SHALL keep HOLD indefinitely, with in_ready=0.
REQ-023 in_valid changes during SHIFT or HOLD SHALL have no effect on the hold register, counter or chain.
REQ-024 Throughput SHALL be one word per WIDTH+2 cycles minimum (accept, WIDTH shifts, HOLD handshake).
REQ-025 Outside SHIFT, sdo SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously), regardless of clk:
- force state IDLE;
- clear the counter, hold register and all chain stages to 0.
REQ-027 Output values during reset SHALL be: in_ready=1, out_valid=0, out_data=0, sdo=0, busy=0.
REQ-028 A reset asserted mid-SHIFT or mid-HOLD SHALL abandon the word; no partial out_valid SHALL occur after release.
REQ-029 The first accept after reset release SHALL require a rising clk edge with rst_n=1.

Structure
REQ-030 A shared package SHALL hold:
- the state enum (IDLE, SHIFT, HOLD);
- the default WIDTH constant.
REQ-031 The chain SHALL be a separate sub-module shiftreg_en: WIDTH stages, serial in, shift enable, async active-low clear, parallel out.
REQ-032 FSM, counter and hold register SHALL reside in shift_ctrl.

Verification
REQ-033 Reset, then accept in_data=6'b101101 with out_ready=1 -> sdo sequence 1,0,1,1,0,1; out_valid high 6 edges after accept; out_data=6'b101101.
REQ-034 Word 6'b000001 with out_ready held 0 for 10 cycles -> out_valid stays 1, out_data stable, in_ready 0; releasing out_ready -> IDLE next edge.
REQ-035 in_valid toggling with 6'b111111 during SHIFT of 6'b010010 -> out_data=6'b010010, with the second word accepted only after return to IDLE.
REQ-036 rst_n pulsed low at the 3rd SHIFT cycle of 6'b110011 -> out_data=0 and IDLE immediately, with no out_valid afterwards until a new accept.
REQ-037 Back-to-back words 6'b100000 then 6'b000011 with in_valid and out_ready held 1 -> accepts spaced 8 cycles apart, and both words are reproduced exactly.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the parallel-to-serial-to-parallel shift controller.
// Holds the controller state encoding and the default word width.
package shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/shiftreg_en.sv
// WIDTH-stage shift chain: serial input enters the top stage, every stage moves down one place.
// Shifting happens only when en is high; the chain clears asynchronously on rst_n low.
module shiftreg_en #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Chain stages: stage k+1 feeds stage k, sin feeds stage WIDTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= {sin, q[WIDTH-1:1]};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Shift controller: accepts a parallel word, streams it LSB first through a shift chain,
// then presents the rebuilt word until the consumer takes it.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sdo,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] hold_s;
    logic            shift_en_s;
    logic            sdo_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic            sdo_r;

    // Next-state, counter and hold-register decode
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hold_s     = hold_r;
        shift_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    hold_s  = in_data;
                    cnt_s   = {CW{1'b0}};
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shift_en_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_s = HOLD;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Serial bit for the coming cycle, so sdo can be a flop yet equal hold[cnt] in SHIFT
    always_comb begin
        if (state_s == SHIFT) begin
            sdo_s = hold_s[cnt_s];
        end else begin
            sdo_s = 1'b0;
        end
    end

    // Controller state, counter and hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            hold_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            hold_r  <= hold_s;
        end
    end

    // Status outputs registered from the next state so they track state_r exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            sdo_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == HOLD);
            busy_r      <= (state_s != IDLE);
            sdo_r       <= sdo_s;
        end
    end

    shiftreg_en #(
        .WIDTH (WIDTH)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en_s),
        .sin   (sdo_r),
        .q     (out_data)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sdo       = sdo_r;

endmodule
